regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file among NUM_REQ write requesters: writeback, load return, and the AXI4-Lite debug write path. Requesters use valid/ready handshakes. A round-robin arbiter grants at most one requester per cycle. The granted write is registered and driven onto the register file write port one cycle later. Writes to x0 are accepted and dropped, so x0 stays zero.

Parameters:
NUM_REQ, 3, number of write requesters (2..8); index 0 = writeback
DATA_W, 32, register data width
ADDR_W, 5, register index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
hold  in  1  arbitration freeze; no new grants while high
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant/accept (combinational)
req_dest  in  NUM_REQ*ADDR_W  flattened destination indices; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  flattened write data; requester i at [i*DATA_W +: DATA_W]
rf_write_en  out  1  register file write enable (registered)
rf_write_dest  out  ADDR_W  register file write index (registered)
rf_write_data  out  DATA_W  register file write data (registered)
grant_idx  out  3  index of last accepted requester (registered)
busy  out  1  high when any req_valid is high or rf_write_en is high

Behaviour:
Reset and timing:
- Reset: reset_n asynchronous, active-low; clock clk.
- Values during/after reset: rf_write_en=0, rf_write_dest=0, rf_write_data=0, grant_idx=0, rr_ptr=NUM_REQ-1, so requester 0 wins the first contested cycle.

Handshake:
- Transfer for requester i occurs on a rising edge with req_valid[i]&&req_ready[i].
- req_ready is one-hot or zero and depends only on req_valid, hold and rr_ptr.
- A requester holds valid/dest/data stable until accepted. The arbiter never withdraws a grant within a cycle.

Arbitration:
- hold=0: search requesters rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. The first with req_valid=1 gets req_ready=1.
- On a transfer, rr_ptr<=granted index and grant_idx<=granted index.
- No valid requester: rr_ptr unchanged.
- hold=1: req_ready=0 for all requesters, rr_ptr unchanged. A write already registered still drives the port in that cycle.

Output stage:
- Latency 1: a transfer at edge N makes rf_write_en=1 with that dest/data during cycle N+1 (written to the register file at edge N+1).
- With no transfer, rf_write_en<=0. dest/data hold their last values.
- One write per cycle max. Back-to-back grants give continuous rf_write_en=1.

x0 rule:
- A transfer with dest=0 completes the handshake but forces rf_write_en<=0 next cycle.
- grant_idx and rr_ptr still update.

Ordering:
- Writes to the same dest from different requesters commit in grant order; the last grant wins.

Reset mid-operation:
- Any registered write is discarded (rf_write_en=0 immediately).
- Requesters must re-present requests after reset_n deasserts.

Fairness:
- With all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.

Test Plan:
1. After reset, only req_valid[1]=1, dest=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle; next cycle rf_write_en=1, dest=5, data=0xDEADBEEF, grant_idx=1; then rf_write_en=0.
2. All three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; rf_write_en high 6 consecutive cycles; each requester accepted twice.
3. req 0 dest=0 data=0x1234 -> ready=001, next cycle rf_write_en=0; a following req 2 dest=0 -> still no write; rr_ptr advances.
4. req 0 and req 2 both valid, dest=7, data 0xA then 0xB, rr_ptr=1 -> req 2 granted first (0xB), then req 0 (0xA); register 7 ends at 0xA.
5. Valid req 1 with hold=1 for 3 cycles -> req_ready=0, rf_write_en=0 after the in-flight write; hold drops -> grant on the next edge.
6. Assert reset_n=0 in the cycle rf_write_en=1 -> rf_write_en, dest and data go to 0 immediately; rr_ptr=2; the first post-reset contested grant goes to req 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Request bundle shared by all register file write requesters.
// master: valid/dest/data out, ready in; slave: the arbiter side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_dest,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dest,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register file write port.
// Ports: clk, reset_n, hold, req (slave bundle), rf_write_*, grant_idx, busy.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  regfile_write_arbiter_if.slave req,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_dest,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [2:0]        grant_idx,
  output logic              busy
);

  logic [2:0]           rr_ptr;
  logic [3:0]           shamt;
  logic [NUM_REQ-1:0]   vrot;
  logic [NUM_REQ-1:0]   sel_rot;
  logic [2*NUM_REQ-1:0] rdbl;
  logic [NUM_REQ-1:0]   ready;
  logic [3:0]           gsum;
  logic [2:0]           gnt;
  logic                 found;
  logic                 xfer;
  logic [ADDR_W-1:0]    sel_dest;
  logic [DATA_W-1:0]    sel_data;

  // Rotate valids so bit 0 is the requester just after rr_ptr.
  assign shamt = {1'b0, rr_ptr} + 4'd1;
  assign vrot  = hold ? '0 :
    NUM_REQ'({req.req_valid, req.req_valid} >> shamt);

  always_comb begin
    sel_rot = '0;
    found   = 1'b0;
    gsum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && vrot[k]) begin
        found      = 1'b1;
        sel_rot[k] = 1'b1;
        gsum       = shamt + 4'(k);
      end
    end
    if (gsum >= 4'(NUM_REQ))
      gsum = gsum - 4'(NUM_REQ);
  end

  // Rotate the one-hot pick back into requester order.
  assign rdbl  = {{NUM_REQ{1'b0}}, sel_rot} << shamt;
  assign ready = rdbl[NUM_REQ-1:0]
               | rdbl[2*NUM_REQ-1:NUM_REQ];
  assign gnt   = gsum[2:0];
  assign xfer  = found;

  assign req.req_ready = ready;

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        sel_dest = req.req_dest[i*ADDR_W +: ADDR_W];
        sel_data = req.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= 3'(NUM_REQ-1);
      grant_idx     <= '0;
      rf_write_en   <= 1'b0;
      rf_write_dest <= '0;
      rf_write_data <= '0;
    end else if (xfer) begin
      rr_ptr      <= gnt;
      grant_idx   <= gnt;
      // x0 writes complete the handshake but never reach the file.
      rf_write_en <= (sel_dest != '0);
      if (sel_dest != '0) begin
        rf_write_dest <= sel_dest;
        rf_write_data <= sel_data;
      end
    end else begin
      rf_write_en <= 1'b0;
    end
  end

  assign busy = (|req.req_valid) | rf_write_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: behavioural round-robin model plus
// directed scenarios and randomized traffic.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hold = 1'b0;
  logic rf_write_en;
  logic [AW-1:0] rf_write_dest;
  logic [DW-1:0] rf_write_data;
  logic [2:0] grant_idx;
  logic busy;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)
  ) rif ();

  regfile_write_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hold(hold),
    .req(rif),
    .rf_write_en(rf_write_en),
    .rf_write_dest(rf_write_dest),
    .rf_write_data(rf_write_data),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  logic [N-1:0]  v;
  logic [AW-1:0] dst [N];
  logic [DW-1:0] dat [N];

  always_comb begin
    rif.req_valid = v;
    rif.req_dest  = '0;
    rif.req_data  = '0;
    for (int i = 0; i < N; i++) begin
      rif.req_dest[i*AW +: AW] = dst[i];
      rif.req_data[i*DW +: DW] = dat[i];
    end
  end

  int m_ptr;
  bit m_en;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;
  int m_gidx;
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] d_rf [32];
  int checks = 0;
  int errors = 0;
  int last_g;
  int gq[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_pick();
    if (hold) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1;
    m_en = 1'b0;
    m_dest = '0;
    m_data = '0;
    m_gidx = 0;
    last_g = -1;
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic cycle();
    logic [N-1:0] er;
    logic cen;
    logic [AW-1:0] cd;
    logic [DW-1:0] cx;
    @(negedge clk);
    last_g = model_pick();
    er = '0;
    if (last_g >= 0) er[last_g] = 1'b1;
    chk("req_ready", 32'(rif.req_ready), 32'(er));
    chk("rf_write_en", 32'(rf_write_en), 32'(m_en));
    if (m_en) begin
      chk("rf_write_dest", 32'(rf_write_dest), 32'(m_dest));
      chk("rf_write_data", rf_write_data, m_data);
    end
    chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
    chk("busy", 32'(busy), 32'((v != 0) || m_en));
    cen = rf_write_en;
    cd = rf_write_dest;
    cx = rf_write_data;
    @(posedge clk);
    if (cen && reset_n) d_rf[cd] = cx;
    if (m_en) m_rf[m_dest] = m_data;
    if (last_g >= 0) begin
      m_ptr = last_g;
      m_gidx = last_g;
      m_en = (dst[last_g] != 0);
      if (m_en) begin
        m_dest = dst[last_g];
        m_data = dat[last_g];
      end
    end else begin
      m_en = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    v = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_order [6];
    int bad;
    exp_order = '{0, 1, 2, 0, 1, 2};
    v = '0;
    for (int i = 0; i < N; i++) begin
      dst[i] = '0;
      dat[i] = '0;
    end
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
    model_reset();
    #12;
    chk("reset_en", 32'(rf_write_en), 0);
    chk("reset_dest", 32'(rf_write_dest), 0);
    chk("reset_data", rf_write_data, 0);
    chk("reset_gidx", 32'(grant_idx), 0);
    chk("reset_ready", 32'(rif.req_ready), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single requester 1
    v = 3'b010;
    dst[1] = 5;
    dat[1] = 32'hDEADBEEF;
    cycle();
    chk("t1_grant", 32'(last_g), 1);
    v = '0;
    chk("t1_en", 32'(rf_write_en), 1);
    chk("t1_dest", 32'(rf_write_dest), 5);
    chk("t1_data", rf_write_data, 32'hDEADBEEF);
    chk("t1_gidx", 32'(grant_idx), 1);
    cycle();
    chk("t1_en_off", 32'(rf_write_en), 0);

    // Fairness with all valid
    apply_reset();
    for (int i = 0; i < N; i++) begin
      dst[i] = AW'(i + 10);
      dat[i] = 32'(i + 100);
    end
    v = '1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("t2_order", 32'(last_g), 32'(exp_order[c]));
      chk("t2_en", 32'(rf_write_en), 1);
    end
    v = '0;
    cycle();

    // Writes to x0
    v = 3'b001;
    dst[0] = 0;
    dat[0] = 32'h1234;
    cycle();
    chk("t3_grant0", 32'(last_g), 0);
    chk("t3_en0", 32'(rf_write_en), 0);
    v = 3'b100;
    dst[2] = 0;
    cycle();
    chk("t3_grant2", 32'(last_g), 2);
    chk("t3_en2", 32'(rf_write_en), 0);
    chk("t3_gidx", 32'(grant_idx), 2);
    v = '0;

    // Same-destination ordering
    v = 3'b010;
    dst[1] = 9;
    dat[1] = 32'h55;
    cycle();
    v = 3'b101;
    dst[0] = 7;
    dat[0] = 32'hA;
    dst[2] = 7;
    dat[2] = 32'hB;
    cycle();
    chk("t4_first", 32'(last_g), 2);
    v[2] = 1'b0;
    cycle();
    chk("t4_second", 32'(last_g), 0);
    v = '0;
    cycle();
    cycle();
    chk("t4_model_r7", m_rf[7], 32'hA);
    chk("t4_dut_r7", d_rf[7], 32'hA);

    // Hold freezes grants
    v = 3'b001;
    dst[0] = 3;
    dat[0] = 32'h33;
    cycle();
    v = 3'b010;
    dst[1] = 4;
    dat[1] = 32'h44;
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t5_no_grant", 32'(last_g + 1), 0);
      chk("t5_en", 32'(rf_write_en), 0);
    end
    hold = 1'b0;
    cycle();
    chk("t5_grant", 32'(last_g), 1);
    v = '0;
    cycle();

    // Reset with a write in flight
    v = 3'b001;
    dst[0] = 6;
    dat[0] = 32'h66;
    cycle();
    v = '0;
    chk("t6_inflight", 32'(rf_write_en), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_en", 32'(rf_write_en), 0);
    chk("t6_dest", 32'(rf_write_dest), 0);
    chk("t6_data", rf_write_data, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v = '1;
    cycle();
    chk("t6_first", 32'(last_g), 0);
    v = '0;
    cycle();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      hold = ($urandom_range(7) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_g == i) v[i] = 1'b0;
        if (!v[i] && $urandom_range(9) < 4) begin
          v[i] = 1'b1;
          dst[i] = ($urandom_range(7) == 0) ? '0 :
                   AW'($urandom_range(31));
          dat[i] = $urandom;
        end
      end
      cycle();
      if (last_g >= 0) gq.push_back(last_g);
    end
    hold = 1'b0;
    v = '0;
    cycle();
    cycle();
    bad = 0;
    for (int r = 0; r < 32; r++)
      if (d_rf[r] !== m_rf[r]) bad++;
    chk("rf_contents", 32'(bad), 0);
    chk("x0_zero", d_rf[0], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
